dds_phase_gen: RTL

- Phase-accumulator front end of the DDS path; sits directly upstream of the sine look-up stage.
- Produces the 10-bit phase index (o_phase) and the qualifying enable (o_en) that the sine stage consumes as its phase input and enable.
- Supports fixed-frequency run, a runtime frequency-word update, a phase offset, and a linear frequency sweep (chirp) with a programmable dwell time.

---
 rtl/dds_phase_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dds_phase_gen.sv
// Phase-accumulator front end of the DDS path: fixed-frequency run, runtime tuning-word
// update, phase offset and linear frequency sweep with a programmable dwell period.
module dds_phase_gen #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 10,
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_sweep_en,
    input  logic               i_ftw_vld,
    input  logic [ACC_W-1:0]   i_ftw,
    input  logic [PHASE_W-1:0] i_poff,
    input  logic [ACC_W-1:0]   i_ftw_end,
    input  logic [ACC_W-1:0]   i_sweep_step,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_en,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_busy,
    output logic               o_sweep_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     ftw_r;
    logic [ACC_W-1:0]     ftw_cur;
    logic [DWELL_W-1:0]   dwell_cnt;

    logic [PHASE_W-1:0]   poff_r;
    logic [ACC_W-1:0]     ftw_end_r;
    logic [ACC_W-1:0]     step_r;
    logic [DWELL_W-1:0]   dwell_r;

    logic                 start_ok;
    logic                 sweep_eval;
    logic                 sweep_finish;
    logic [ACC_W:0]       sweep_sum;
    logic                 en_next;

    assign start_ok = i_start && !i_stop;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next   = state;
        sweep_eval   = 1'b0;
        sweep_finish = 1'b0;
        // One extra bit so a sweep near the top of the range cannot wrap past ftw_end.
        sweep_sum    = {1'b0, ftw_cur} + {1'b0, step_r};

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = i_sweep_en ? SWEEP : RUN;
                end
            end
            RUN: begin
                if (i_stop) begin
                    state_next = IDLE;
                end
            end
            SWEEP: begin
                if (i_stop) begin
                    state_next = IDLE;
                end else if (dwell_cnt == dwell_r) begin
                    sweep_eval = 1'b1;
                    if (sweep_sum >= {1'b0, ftw_end_r}) begin
                        sweep_finish = 1'b1;
                        state_next   = RUN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign en_next = (state != IDLE) && !i_stop;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            acc          <= '0;
            ftw_r        <= '0;
            ftw_cur      <= '0;
            dwell_cnt    <= '0;
            poff_r       <= '0;
            ftw_end_r    <= '0;
            step_r       <= '0;
            dwell_r      <= '0;
            o_en         <= 1'b0;
            o_phase      <= '0;
            o_busy       <= 1'b0;
            o_sweep_done <= 1'b0;
        end else begin
            state  <= state_next;
            o_busy <= (state_next != IDLE);

            if (i_ftw_vld) begin
                ftw_r <= i_ftw;
            end

            case (state)
                IDLE: begin
                    acc       <= '0;
                    dwell_cnt <= '0;
                    if (start_ok) begin
                        // ftw_r, not i_ftw: a load arriving with start only affects later starts.
                        ftw_cur   <= ftw_r;
                        poff_r    <= i_poff;
                        ftw_end_r <= i_ftw_end;
                        step_r    <= i_sweep_step;
                        dwell_r   <= i_dwell;
                    end
                end
                RUN: begin
                    acc <= i_stop ? '0 : acc + ftw_cur;
                    if (i_ftw_vld) begin
                        ftw_cur <= i_ftw;
                    end
                end
                SWEEP: begin
                    if (i_stop) begin
                        acc       <= '0;
                        dwell_cnt <= '0;
                    end else begin
                        acc <= acc + ftw_cur;
                        if (sweep_eval) begin
                            dwell_cnt <= '0;
                            ftw_cur   <= sweep_finish ? ftw_end_r : sweep_sum[ACC_W-1:0];
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end
                    end
                end
                default: acc <= '0;
            endcase

            o_en         <= en_next;
            o_phase      <= en_next ? acc[ACC_W-1 -: PHASE_W] + poff_r : '0;
            o_sweep_done <= sweep_finish;
        end
    end

endmodule
